led_mode_scheduler: RTL and testbench
=====================================

# led_mode_scheduler

Sequencer for the LED display datapath: counter, gray encoder and display mux. It rotates the display mux select through an enabled subset of modes, each held for a programmable dwell time, with an optional blanking gap between modes. It also gates the free-running counter enable. It sits between the UART register file outputs and the counter/mux instances in the blinky top level. Configuration is double-buffered so that register writes never glitch a mode mid-dwell.

## Interface
- N_STATES, 4, number of mux modes (≥2)
- SEL_WIDTH, $clog2(N_STATES), mux select width
- DWELL_WIDTH, 32, dwell counter width
- BLANK_CYCLES, 0, blanking gap length in clk cycles (0 = no gap)

- clk  in  1  system clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_enable  in  1  scheduler run enable (level)
- i_cfg_valid  in  1  one-cycle pulse: capture config inputs into shadow
- i_auto  in  1  config: 1 = auto-rotate, 0 = manual select
- i_manual_sel  in  SEL_WIDTH  config: select used in manual mode
- i_mode_mask  in  N_STATES  config: bit k set = mode k in rotation
- i_dwell  in  DWELL_WIDTH  config: dwell length in cycles (0 treated as 1)
- o_select  out  SEL_WIDTH  registered mux select
- o_counter_en  out  1  counter enable
- o_blank  out  1  high during blanking gap (top forces LEDs off)
- o_switch  out  1  one-cycle pulse when o_select changes

## Operation
- Shadow registers hold the captured config. i_cfg_valid loads them on the next edge.
- Reset values of the shadow registers: auto=0, manual_sel=0, mask=1, dwell=1.
- Active config is copied from the shadow only at an apply point: in IDLE every cycle, or on the final cycle of DWELL.
- When i_cfg_valid coincides with an apply point, the new values take effect at that point (write-through).
- FSM states are IDLE, DWELL and BLANK.
- IDLE:
  - Entered on reset and whenever i_enable=0.
  - o_counter_en=0; o_select holds its value.
  - i_enable=1 moves to DWELL with the dwell counter cleared.
- DWELL:
  - o_counter_en=1.
  - Manual mode: o_select=active manual_sel, and the dwell counter does not run. If manual_sel ≥ N_STATES, o_select holds its previous value.
  - Auto mode: the counter increments each cycle. It expires when count = max(dwell,1)−1.
  - On expiry, next = first set mask bit strictly after the current select, searching circularly (wrap N_STATES−1→0).
  - If next == current, or the mask is all zero: no change, no o_switch, counter restarts, and the state stays DWELL.
  - Otherwise go to BLANK, or go straight to DWELL with the new select if BLANK_CYCLES=0.
- BLANK: o_blank=1, o_counter_en=0, lasts exactly BLANK_CYCLES cycles, then DWELL with the new select.
- Mode change: o_select updates and o_switch pulses in the same cycle, which is the first cycle of the new DWELL.
- Auto→manual change at an apply point: o_select jumps to manual_sel, and o_switch pulses if the value differs.
- i_enable=0 in any state goes to IDLE next cycle. A pending BLANK is abandoned and o_select is not advanced.
- Reset values of all outputs are 0. State resets to IDLE and the dwell counter to 0.

## Timing
- All outputs are registered; inputs to outputs take 1 cycle.
- With dwell = D and BLANK_CYCLES = B, a mode occupies D cycles and the next mode begins D+B cycles after the previous o_switch.
- i_cfg_valid to effect is 1 cycle in IDLE, otherwise at the end of the current dwell.
- Reset asserted mid-operation: next edge gives all outputs 0 and state IDLE; shadows return to their defaults.
- The counter compares against the full DWELL_WIDTH; there is no overflow since expiry occurs at or before 2^DWELL_WIDTH−1.

## Structure
- Package led_sched_pkg: state enum (IDLE, DWELL, BLANK) and a function computing the select width from N_STATES.
- Sub-module rr_next_set: combinational circular search for the next set bit after an index. Outputs are found and index.
- Everything else (FSM, dwell counter, shadow/active registers) lives in one module.

## Test plan
- Reset, then i_enable=1 with default config → o_select stays 0, o_counter_en=1 from cycle 1, o_switch never pulses.
- Config mask=4'b1011, dwell=3, auto=1, B=0 → o_select sequence 0,1,3,0 with each value held 3 cycles; o_switch pulses on each change.
- Same config with BLANK_CYCLES=2 → o_blank high for 2 cycles between modes, o_counter_en low during the gap, period 5 cycles.
- Mid-dwell i_cfg_valid with dwell=10 → current mode completes its old dwell; the next mode holds 10 cycles.
- Switch to manual_sel=2 while at mode 0 → select becomes 2 at the dwell end with an o_switch pulse. Then manual_sel=7 (N_STATES=4) → select holds at 2.
- Drop i_enable or i_reset_n during BLANK → IDLE next cycle, o_blank=0 and o_select unchanged (enable) or 0 (reset).

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED mode scheduler.
//   sched_state_e : scheduler FSM states (idle, dwelling on a mode, blanking gap)
//   sel_width()   : width of a mux select able to address n modes
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } sched_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_set.sv
// Combinational circular search for the first set mask bit strictly after an
// index. The index itself is the last candidate, so a mask holding only the
// current bit returns the current index.
//   i_mask  : candidate bit set
//   i_idx   : starting index (not itself preferred)
//   o_found : mask has at least one set bit
//   o_index : first set bit after i_idx, wrapping N-1 -> 0
module rr_next_set #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_idx,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  int best;
  int off;

  always_comb begin
    o_found = |i_mask;
    o_index = i_idx;
    best    = N + 1;
    off     = 0;
    for (int j = 0; j < N; j++) begin
      // Circular distance from i_idx to j; j == i_idx counts as a full turn.
      off = j - int'(i_idx);
      if (off <= 0) off = off + N;
      if (i_mask[j] && (off < best)) begin
        best    = off;
        o_index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// Sequencer for the LED display datapath. Rotates the display mux select
// through the enabled modes, holding each for a programmable dwell, with an
// optional blanking gap between modes, and gates the free-running counter.
// Configuration is double-buffered: writes land in a shadow copy and only
// reach the running config at an apply point (every IDLE cycle, every manual
// DWELL cycle, or the final cycle of an auto dwell).
//   clk, i_reset_n : clock, synchronous active-low reset
//   i_enable       : run enable (level)
//   i_cfg_valid    : capture i_auto/i_manual_sel/i_mode_mask/i_dwell
//   o_select       : registered mux select
//   o_counter_en   : counter enable (high while dwelling)
//   o_blank        : high during the blanking gap
//   o_switch       : one-cycle pulse in the first cycle of a new select
module led_mode_scheduler
  import led_sched_pkg::*;
#(
  parameter int N_STATES     = 4,
  parameter int SEL_WIDTH    = sel_width(N_STATES),
  parameter int DWELL_WIDTH  = 32,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  input  logic                   i_auto,
  input  logic [SEL_WIDTH-1:0]   i_manual_sel,
  input  logic [N_STATES-1:0]    i_mode_mask,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  output logic [SEL_WIDTH-1:0]   o_select,
  output logic                   o_counter_en,
  output logic                   o_blank,
  output logic                   o_switch
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);

  sched_state_e state_q, state_d;

  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   pend_q, pend_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic                   en_q, en_d;
  logic                   blank_q, blank_d;
  logic                   switch_q, switch_d;

  // Shadow next-state doubles as the effective config at an apply point, so
  // a write coinciding with an apply point takes effect immediately.
  logic                   sh_auto_q, sh_auto_d;
  logic [SEL_WIDTH-1:0]   sh_sel_q, sh_sel_d;
  logic [N_STATES-1:0]    sh_mask_q, sh_mask_d;
  logic [DWELL_WIDTH-1:0] sh_dwell_q, sh_dwell_d;

  // Select and mask are only consulted at apply points, where the freshly
  // applied value is used directly, so only auto and dwell need a running copy.
  logic                   act_auto_q, act_auto_d;
  logic [DWELL_WIDTH-1:0] act_dwell_q, act_dwell_d;

  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   apply;
  logic                   nx_found;
  logic [SEL_WIDTH-1:0]   nx_idx;

  assign sh_auto_d  = i_cfg_valid ? i_auto       : sh_auto_q;
  assign sh_sel_d   = i_cfg_valid ? i_manual_sel : sh_sel_q;
  assign sh_mask_d  = i_cfg_valid ? i_mode_mask  : sh_mask_q;
  assign sh_dwell_d = i_cfg_valid ? i_dwell      : sh_dwell_q;

  // A dwell of 0 behaves as 1.
  assign dwell_last = (act_dwell_q == '0) ? '0 : act_dwell_q - DWELL_WIDTH'(1);

  // Manual mode has no dwell to finish, so every manual cycle is an apply point.
  assign apply = (state_q == ST_IDLE) ||
                 ((state_q == ST_DWELL) && (!act_auto_q || (cnt_q == dwell_last)));

  assign act_auto_d  = apply ? sh_auto_d  : act_auto_q;
  assign act_dwell_d = apply ? sh_dwell_d : act_dwell_q;

  rr_next_set #(
    .N  (N_STATES),
    .IW (SEL_WIDTH)
  ) u_next (
    .i_mask  (sh_mask_d),
    .i_idx   (sel_q),
    .o_found (nx_found),
    .o_index (nx_idx)
  );

  always_ff @(posedge clk) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (apply) begin
          cnt_d = '0;
          if (!sh_auto_d) begin
            // Out-of-range manual selects leave the display where it is.
            if (32'(sh_sel_d) < N_STATES) sel_d = sh_sel_d;
          end else if (act_auto_q && nx_found && (nx_idx != sel_q)) begin
            if (BLANK_CYCLES == 0) begin
              sel_d = nx_idx;
            end else begin
              state_d = ST_BLANK;
              pend_d  = nx_idx;
              bcnt_d  = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + DWELL_WIDTH'(1);
        end
      end
      ST_BLANK: begin
        if (bcnt_q == B_LAST) begin
          state_d = ST_DWELL;
          sel_d   = pend_q;
          cnt_d   = '0;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable wins everywhere: any pending mode change is dropped.
    if (!i_enable) begin
      state_d = ST_IDLE;
      sel_d   = sel_q;
      cnt_d   = '0;
    end
  end

  always_comb begin
    en_d     = (state_d == ST_DWELL);
    blank_d  = (state_d == ST_BLANK);
    switch_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      sel_q       <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      en_q        <= 1'b0;
      blank_q     <= 1'b0;
      switch_q    <= 1'b0;
      sh_auto_q   <= 1'b0;
      sh_sel_q    <= '0;
      sh_mask_q   <= N_STATES'(1);
      sh_dwell_q  <= DWELL_WIDTH'(1);
      act_auto_q  <= 1'b0;
      act_dwell_q <= DWELL_WIDTH'(1);
    end else begin
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      en_q        <= en_d;
      blank_q     <= blank_d;
      switch_q    <= switch_d;
      sh_auto_q   <= sh_auto_d;
      sh_sel_q    <= sh_sel_d;
      sh_mask_q   <= sh_mask_d;
      sh_dwell_q  <= sh_dwell_d;
      act_auto_q  <= act_auto_d;
      act_dwell_q <= act_dwell_d;
    end
  end

  assign o_select     = sel_q;
  assign o_counter_en = en_q;
  assign o_blank      = blank_q;
  assign o_switch     = switch_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Bench for led_mode_scheduler. Three instances share one stimulus stream:
//   u_a : 4 modes, no blanking gap
//   u_b : 4 modes, 2-cycle blanking gap
//   u_c : 5 modes, 1-cycle gap (lets an out-of-range manual select be driven)
// Each instance has its own reference model written as a dwell countdown.
module tb_led_mode_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, cv, auto_in;
  logic [2:0]  sel_in;
  logic [4:0]  mask_in;
  logic [31:0] dwell_in;

  logic [1:0] a_sel, b_sel;
  logic [2:0] c_sel;
  logic a_en, a_blank, a_sw;
  logic b_en, b_blank, b_sw;
  logic c_en, c_blank, c_sw;

  led_mode_scheduler #(.N_STATES(4), .DWELL_WIDTH(32), .BLANK_CYCLES(0)) u_a (
    .clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_cfg_valid(cv), .i_auto(auto_in),
    .i_manual_sel(sel_in[1:0]), .i_mode_mask(mask_in[3:0]), .i_dwell(dwell_in),
    .o_select(a_sel), .o_counter_en(a_en), .o_blank(a_blank), .o_switch(a_sw));

  led_mode_scheduler #(.N_STATES(4), .DWELL_WIDTH(32), .BLANK_CYCLES(2)) u_b (
    .clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_cfg_valid(cv), .i_auto(auto_in),
    .i_manual_sel(sel_in[1:0]), .i_mode_mask(mask_in[3:0]), .i_dwell(dwell_in),
    .o_select(b_sel), .o_counter_en(b_en), .o_blank(b_blank), .o_switch(b_sw));

  led_mode_scheduler #(.N_STATES(5), .DWELL_WIDTH(32), .BLANK_CYCLES(1)) u_c (
    .clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_cfg_valid(cv), .i_auto(auto_in),
    .i_manual_sel(sel_in), .i_mode_mask(mask_in), .i_dwell(dwell_in),
    .o_select(c_sel), .o_counter_en(c_en), .o_blank(c_blank), .o_switch(c_sw));

  localparam int NS [3] = '{4, 4, 5};
  localparam int BC [3] = '{0, 2, 1};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: phase 0 idle, 1 dwell, 2 blank.
  int     m_st [3], m_sel [3], m_pend [3], m_bleft [3];
  longint m_left [3];
  int     sh_auto [3], sh_sel [3], sh_mask [3];
  longint sh_dw [3];
  int     ac_auto [3];
  longint ac_dw [3];
  int     m_en [3], m_blank [3], m_sw [3];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint lmax1(input longint x);
    return (x < 1) ? 1 : x;
  endfunction

  // First enabled mode after cur going round the ring; cur itself comes last.
  function automatic int next_mode(input int mask, input int cur, input int n);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (cur + k) % n;
      if (((mask >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int n, b, i_sel, i_mask, old_auto, ns, nsel, nx;
      n      = NS[d];
      b      = BC[d];
      i_sel  = (n > 4) ? int'(sel_in) : int'(sel_in) % 4;
      i_mask = int'(mask_in) % (1 << n);
      if (!rst_n) begin
        m_st[d] = 0; m_sel[d] = 0; m_pend[d] = 0; m_bleft[d] = 0; m_left[d] = 1;
        sh_auto[d] = 0; sh_sel[d] = 0; sh_mask[d] = 1; sh_dw[d] = 1;
        ac_auto[d] = 0; ac_dw[d] = 1;
        m_en[d] = 0; m_blank[d] = 0; m_sw[d] = 0;
      end else begin
        if (cv) begin
          sh_auto[d] = int'(auto_in); sh_sel[d] = i_sel;
          sh_mask[d] = i_mask;        sh_dw[d]  = longint'(dwell_in);
        end
        ns       = m_st[d];
        nsel     = m_sel[d];
        old_auto = ac_auto[d];
        case (m_st[d])
          0: begin
            ac_auto[d] = sh_auto[d]; ac_dw[d] = sh_dw[d];
            m_left[d]  = lmax1(sh_dw[d]);
            if (en) ns = 1;
          end
          1: begin
            if ((old_auto == 0) || (m_left[d] == 1)) begin
              ac_auto[d] = sh_auto[d]; ac_dw[d] = sh_dw[d];
              m_left[d]  = lmax1(sh_dw[d]);
              if (sh_auto[d] == 0) begin
                if (sh_sel[d] < n) nsel = sh_sel[d];
              end else if (old_auto != 0) begin
                nx = next_mode(sh_mask[d], m_sel[d], n);
                if ((nx >= 0) && (nx != m_sel[d])) begin
                  if (b == 0) nsel = nx;
                  else begin
                    ns = 2; m_pend[d] = nx; m_bleft[d] = b;
                  end
                end
              end
            end else begin
              m_left[d] = m_left[d] - 1;
            end
          end
          default: begin
            m_bleft[d] = m_bleft[d] - 1;
            if (m_bleft[d] == 0) begin
              ns = 1; nsel = m_pend[d]; m_left[d] = lmax1(ac_dw[d]);
            end
          end
        endcase
        if (!en) begin
          ns = 0; nsel = m_sel[d];
        end
        m_sw[d]    = (nsel != m_sel[d]) ? 1 : 0;
        m_sel[d]   = nsel;
        m_st[d]    = ns;
        m_en[d]    = (ns == 1) ? 1 : 0;
        m_blank[d] = (ns == 2) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    check("A.select", a_sel, m_sel[0]);   check("A.counter_en", a_en, m_en[0]);
    check("A.blank", a_blank, m_blank[0]); check("A.switch", a_sw, m_sw[0]);
    check("B.select", b_sel, m_sel[1]);   check("B.counter_en", b_en, m_en[1]);
    check("B.blank", b_blank, m_blank[1]); check("B.switch", b_sw, m_sw[1]);
    check("C.select", c_sel, m_sel[2]);   check("C.counter_en", c_en, m_en[2]);
    check("C.blank", c_blank, m_blank[2]); check("C.switch", c_sw, m_sw[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg(input logic a, input logic [2:0] s, input logic [4:0] m, input logic [31:0] dw);
    cv = 1'b1; auto_in = a; sel_in = s; mask_in = m; dwell_in = dw;
    tick();
    cv = 1'b0;
  endtask

  task automatic wait_blank_b();
    for (int i = 0; i < 60; i++) begin
      if (b_blank) break;
      tick();
    end
    check("B.blank_reached", b_blank, 1);
  endtask

  initial begin
    logic [1:0] held;
    rst_n = 1'b0; en = 1'b0; cv = 1'b0; auto_in = 1'b0;
    sel_in = '0; mask_in = '0; dwell_in = '0;
    repeat (3) tick();
    check("reset.A_select", a_sel, 0);
    check("reset.B_counter_en", b_en, 0);

    // Default config: manual mode 0, no switching.
    rst_n = 1'b1; en = 1'b1;
    repeat (20) tick();

    // Auto rotation 0,1,3,0 with dwell 3.
    cfg(1'b1, 3'd0, 5'b01011, 32'd3);
    repeat (30) tick();

    // Mid-dwell rewrite of dwell to 10.
    tick();
    cfg(1'b1, 3'd0, 5'b01011, 32'd10);
    repeat (45) tick();

    // Manual select 2, then 7 (out of range for 5 modes; wraps to 3 for 4 modes).
    cfg(1'b0, 3'd2, 5'b01011, 32'd10);
    repeat (25) tick();
    check("C.manual2", c_sel, 2);
    cfg(1'b0, 3'd7, 5'b01011, 32'd10);
    repeat (10) tick();
    check("C.manual7_hold", c_sel, 2);

    // Drop enable during the blanking gap.
    cfg(1'b1, 3'd0, 5'b01011, 32'd3);
    wait_blank_b();
    held = b_sel;
    en = 1'b0;
    tick();
    check("B.disable_blank", b_blank, 0);
    check("B.disable_select", b_sel, held);
    en = 1'b1;
    repeat (10) tick();

    // Reset during the blanking gap.
    wait_blank_b();
    rst_n = 1'b0;
    tick();
    check("B.reset_select", b_sel, 0);
    check("B.reset_blank", b_blank, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(199) != 0);
      en    = ($urandom_range(39) != 0);
      cv    = ($urandom_range(14) == 0);
      if (cv) begin
        auto_in  = ($urandom_range(3) != 0);
        sel_in   = 3'($urandom_range(7));
        mask_in  = 5'($urandom);
        dwell_in = ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(6, 1));
      end
      tick();
    end
    cv = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
